// File: rtl/inpass_cfg_ctrl_if.sv
// Config-beat bus between a configuration source and inpass_cfg_ctrl.
// Latency: none (wires only).
// Backpressure: cfg_ready from the slave qualifies each cfg_valid beat.
// Signals: cfg_start/cfg_abort frame control, cfg_valid/cfg_wdata beat, cfg_ready.
interface inpass_cfg_ctrl_if #(
  parameter int BITS_PER_BEL = 4
);
  logic                    cfg_start;
  logic                    cfg_abort;
  logic                    cfg_valid;
  logic [BITS_PER_BEL-1:0] cfg_wdata;
  logic                    cfg_ready;

  modport master (
    output cfg_start,
    output cfg_abort,
    output cfg_valid,
    output cfg_wdata,
    input  cfg_ready
  );

  modport slave (
    input  cfg_start,
    input  cfg_abort,
    input  cfg_valid,
    input  cfg_wdata,
    output cfg_ready
  );
endinterface

// File: rtl/inpass_cfg_ctrl.sv
// Loads per-BEL input-pass config words into a shadow register, verifies an XOR
// checksum beat, and commits the shadow to ConfigBits only on a matching checksum.
// Latency: commit and done appear 2 edges after the checksum beat is accepted.
// Backpressure: cfg_ready is high for the whole LOAD state; cfg_valid low stalls.
// Ports: UserCLK/resetn; cfg (slave modport: start, abort, valid, wdata, ready);
//        ConfigBits (active config), busy (not IDLE), done (pulse), err (sticky).
module inpass_cfg_ctrl #(
  parameter int NUM_BELS     = 4,
  parameter int BITS_PER_BEL = 4
) (
  input  logic                             UserCLK,
  input  logic                             resetn,
  inpass_cfg_ctrl_if.slave                 cfg,
  output logic [NUM_BELS*BITS_PER_BEL-1:0] ConfigBits,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int IDXW = $clog2(NUM_BELS + 1);
  localparam int CW   = NUM_BELS * BITS_PER_BEL;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [CW-1:0]           shadow_q, shadow_d;
  logic [BITS_PER_BEL-1:0] csum_q, csum_d;
  logic [BITS_PER_BEL-1:0] rxsum_q, rxsum_d;
  logic [CW-1:0]           cfg_q, cfg_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic accept;
  logic last_beat;

  assign accept    = cfg.cfg_valid && (state_q == LOAD);
  assign last_beat = (idx_q == IDXW'(NUM_BELS));

  // State register
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort beats start, start beats a same-cycle beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg.cfg_start && !cfg.cfg_abort) state_d = LOAD;
      end
      LOAD: begin
        if (cfg.cfg_abort)                state_d = IDLE;
        else if (cfg.cfg_start)           state_d = LOAD;
        else if (accept && last_beat)     state_d = CHECK;
      end
      CHECK: begin
        // Single-cycle state whether or not an abort arrives
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; state_q is a flop so busy is registered
  always_comb begin
    cfg.cfg_ready = (state_q == LOAD);
    busy          = (state_q != IDLE);
  end

  // Datapath next-state
  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    csum_d   = csum_q;
    rxsum_d  = rxsum_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (cfg.cfg_start && !cfg.cfg_abort) begin
          idx_d  = '0;
          csum_d = '0;
          err_d  = 1'b0;
        end
      end
      LOAD: begin
        if (cfg.cfg_abort) begin
          // Frame dropped; shadow leftovers are harmless since commit needs a full frame
        end else if (cfg.cfg_start) begin
          idx_d  = '0;
          csum_d = '0;
        end else if (accept) begin
          if (!last_beat) begin
            for (int i = 0; i < NUM_BELS; i++) begin
              if (idx_q == IDXW'(i)) begin
                shadow_d[i*BITS_PER_BEL +: BITS_PER_BEL] = cfg.cfg_wdata;
              end
            end
            csum_d = csum_q ^ cfg.cfg_wdata;
            idx_d  = idx_q + IDXW'(1);
          end else begin
            rxsum_d = cfg.cfg_wdata;
          end
        end
      end
      CHECK: begin
        if (!cfg.cfg_abort) begin
          done_d = 1'b1;
          if (rxsum_q == csum_q) cfg_d = shadow_q;
          else                   err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      idx_q    <= '0;
      shadow_q <= '0;
      csum_q   <= '0;
      rxsum_q  <= '0;
      cfg_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      csum_q   <= csum_d;
      rxsum_q  <= rxsum_d;
      cfg_q    <= cfg_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ConfigBits = cfg_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inpass_cfg_ctrl.sv
// Directed bench for inpass_cfg_ctrl: good frame, bad checksum, stalled frame,
// abort / start+abort / restart, and reset mid-frame.
module tb_inpass_cfg_ctrl;

  logic        UserCLK = 1'b0;
  logic        resetn  = 1'b0;
  logic [15:0] ConfigBits;
  logic        busy, done, err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 UserCLK = ~UserCLK;

  inpass_cfg_ctrl_if #(.BITS_PER_BEL(4)) bus ();

  inpass_cfg_ctrl #(
    .NUM_BELS    (4),
    .BITS_PER_BEL(4)
  ) dut (
    .UserCLK   (UserCLK),
    .resetn    (resetn),
    .cfg       (bus),
    .ConfigBits(ConfigBits),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick;
    @(posedge UserCLK);
    #1;
  endtask

  task automatic beat(input logic [3:0] d);
    bus.cfg_valid = 1'b1;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic start_frame;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  // Sends 4 words (w[3:0] first) plus checksum, then steps through CHECK.
  // Returns on the cycle where done is expected high.
  task automatic load_frame(input string tag, input logic [15:0] w,
                            input logic [3:0] ck, input bit gap);
    for (int i = 0; i < 5; i++) begin
      if (gap) begin
        bus.cfg_valid = 1'b0;
        tick();
        chk({tag, "_stall_rdy"}, {31'd0, bus.cfg_ready}, 32'd1);
      end
      chk({tag, "_rdy"}, {31'd0, bus.cfg_ready}, 32'd1);
      bus.cfg_valid = 1'b1;
      bus.cfg_wdata = (i < 4) ? w[i*4 +: 4] : ck;
      tick();
    end
    bus.cfg_valid = 1'b0;
    chk({tag, "_in_check"}, {29'd0, busy, bus.cfg_ready, done}, 32'b100);
    tick();
  endtask

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_abort = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_wdata = '0;

    // Reset state
    #1;
    chk("rst_cfg", {16'd0, ConfigBits}, 32'h0);
    chk("rst_flags", {28'd0, busy, done, err, bus.cfg_ready}, 32'h0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("post_rel_busy", {31'd0, busy}, 32'd0);

    // Good frame 1,2,4,8 checksum F
    start_frame();
    chk("good_busy", {31'd0, busy}, 32'd1);
    load_frame("good", 16'h8421, 4'hF, 1'b0);
    chk("good_done", {31'd0, done}, 32'd1);
    chk("good_cfg", {16'd0, ConfigBits}, 32'h8421);
    chk("good_err", {31'd0, err}, 32'd0);
    chk("good_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("good_done_once", {31'd0, done}, 32'd0);

    // Bad checksum: 3^3^3^3 = 0, send 1
    start_frame();
    load_frame("bad", 16'h3333, 4'h1, 1'b0);
    chk("bad_done", {31'd0, done}, 32'd1);
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_cfg", {16'd0, ConfigBits}, 32'h8421);
    tick();
    chk("bad_done_once", {31'd0, done}, 32'd0);
    chk("bad_err_sticky", {31'd0, err}, 32'd1);

    // Stalled frame: A,5,F,0 checksum 0
    start_frame();
    chk("bp_err_clr", {31'd0, err}, 32'd0);
    load_frame("bp", 16'h0F5A, 4'h0, 1'b1);
    chk("bp_done", {31'd0, done}, 32'd1);
    chk("bp_cfg", {16'd0, ConfigBits}, 32'h0F5A);
    chk("bp_err", {31'd0, err}, 32'd0);
    tick();

    // Abort after two beats, with a beat offered on the abort cycle
    start_frame();
    beat(4'h1);
    beat(4'h2);
    bus.cfg_abort = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_wdata = 4'h4;
    tick();
    bus.cfg_abort = 1'b0;
    bus.cfg_valid = 1'b0;
    chk("abort_idle", {30'd0, busy, done}, 32'b00);
    tick();
    chk("abort_no_done", {31'd0, done}, 32'd0);
    chk("abort_cfg", {16'd0, ConfigBits}, 32'h0F5A);

    // Start together with abort in IDLE stays IDLE
    bus.cfg_start = 1'b1;
    bus.cfg_abort = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    bus.cfg_abort = 1'b0;
    chk("stab_idle", {30'd0, busy, bus.cfg_ready}, 32'b00);
    tick();
    chk("stab_idle2", {31'd0, busy}, 32'd0);

    // Restart after 3 beats; the beat on the restart cycle is dropped
    start_frame();
    beat(4'h1);
    beat(4'h2);
    beat(4'h3);
    bus.cfg_start = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_wdata = 4'h7;
    tick();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_no_done", {31'd0, done}, 32'd0);
    load_frame("restart", 16'h963C, 4'h0, 1'b0);
    chk("restart_done", {31'd0, done}, 32'd1);
    chk("restart_cfg", {16'd0, ConfigBits}, 32'h963C);
    chk("restart_err", {31'd0, err}, 32'd0);
    tick();

    // Reset mid-LOAD with ConfigBits 8421 and two beats accepted
    start_frame();
    load_frame("pre_rst", 16'h8421, 4'hF, 1'b0);
    chk("pre_rst_cfg", {16'd0, ConfigBits}, 32'h8421);
    tick();
    start_frame();
    beat(4'h5);
    beat(4'h6);
    resetn = 1'b0;
    #1;
    chk("midrst_cfg", {16'd0, ConfigBits}, 32'h0);
    chk("midrst_flags", {28'd0, busy, done, err, bus.cfg_ready}, 32'h0);
    tick();
    resetn = 1'b1;
    tick();
    chk("midrst_after", {29'd0, busy, done, err}, 32'h0);
    chk("midrst_cfg_hold", {16'd0, ConfigBits}, 32'h0);
    start_frame();
    load_frame("post_rst", 16'h8421, 4'hF, 1'b0);
    chk("post_rst_done", {31'd0, done}, 32'd1);
    chk("post_rst_cfg", {16'd0, ConfigBits}, 32'h8421);
    chk("post_rst_err", {31'd0, err}, 32'd0);
    tick();
    chk("post_rst_done_once", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
